// File: rtl/stream_pkg.sv
// Shared definitions for the stream packet sink: receive-side FSM encoding.
package stream_pkg;

  typedef enum logic [1:0] {
    RECV = 2'd0,
    DROP = 2'd1,
    DONE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/stream_pkt_buf.sv
// Simple dual-port packet RAM, 2**AW x DW, one write port and one registered read port.
module stream_pkt_buf #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Storage is never cleared; only the read register sees reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The read register holds its value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/stream_pkt_rx.sv
// Stream packet sink: captures one whole packet, then serves it as a word sequence.
// Handshake: a stream word transfers on a rising clk edge where s_valid && s_ready are both 1.
module stream_pkt_rx
  import stream_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  input  logic          s_last,
  output logic          s_ready,
  output logic          pkt_valid,
  output logic [AW:0]   pkt_len,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_data_valid,
  input  logic          pkt_ack,
  output logic [CW-1:0] drop_count
);

  localparam logic [AW-1:0] WMAX     = '1;
  localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] WCNT_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = '1;

  rx_state_e     state;
  rx_state_e     state_nxt;
  logic [AW-1:0] wcnt;
  logic [AW:0]   rcnt;
  logic          accept;
  logic          wr_en;
  logic          rd_fire;

  assign s_ready   = (state != DONE);
  assign pkt_valid = (state == DONE);
  assign accept    = s_valid && s_ready;
  assign wr_en     = (state == RECV) && accept;
  assign rd_fire   = (state == DONE) && rd_en && (rcnt < pkt_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RECV;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RECV: begin
        if (accept) begin
          if (s_last) begin
            state_nxt = DONE;
          end else if (wcnt == WMAX) begin
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        if (accept && s_last) begin
          state_nxt = RECV;
        end
      end
      DONE: begin
        if (pkt_ack) begin
          state_nxt = RECV;
        end
      end
      default: state_nxt = RECV;
    endcase
  end

  // wcnt wraps to zero on entering DROP and is parked at zero while discarding.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt    <= '0;
      pkt_len <= '0;
    end else if (wr_en) begin
      wcnt <= s_last ? '0 : (wcnt + WCNT_ONE);
      if (s_last) begin
        pkt_len <= {1'b0, wcnt} + LEN_ONE;
      end
    end else if (state != RECV) begin
      wcnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt <= '0;
    end else if (state != DONE || pkt_ack) begin
      rcnt <= '0;
    end else if (rd_fire) begin
      rcnt <= rcnt + LEN_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= rd_fire;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (state == DROP && accept && s_last && drop_count != CNT_MAX) begin
      drop_count <= drop_count + CNT_ONE;
    end
  end

  stream_pkt_buf #(
    .AW(AW),
    .DW(DW)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_en),
    .waddr(wcnt),
    .wdata(s_data),
    .re   (rd_fire),
    .raddr(rcnt[AW-1:0]),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_stream_pkt_rx.sv
// Directed bench for stream_pkt_rx with a small buffer (AW=3) and a 2-bit drop counter.
module tb_stream_pkt_rx;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          pkt_valid;
  logic [AW:0]   pkt_len;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          pkt_ack = 1'b0;
  logic [CW-1:0] drop_count;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];

  stream_pkt_rx #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .pkt_valid    (pkt_valid),
    .pkt_len      (pkt_len),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_data_valid(rd_data_valid),
    .pkt_ack      (pkt_ack),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; rd_en = 1'b0; pkt_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic last);
    int guard;
    guard = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    while (!s_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      bad++;
      $display("FAIL push_timeout: s_ready=%0b required 1", s_ready);
    end
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic rd_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic ack();
    pkt_ack = 1'b1;
    tick();
    pkt_ack = 1'b0;
  endtask

  // Reads every queued expected word and compares rd_data/rd_data_valid.
  task automatic drain_and_check(input string tag);
    logic [DW-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      rd_one();
      total++;
      if (rd_data_valid !== 1'b1 || rd_data !== e) begin
        bad++;
        $display("FAIL %s_rd: valid=%0b data=%02h required valid=1 data=%02h",
                 tag, rd_data_valid, rd_data, e);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (s_ready !== 1'b1 || pkt_valid !== 1'b0 || pkt_len !== '0 || rd_data !== '0 ||
        rd_data_valid !== 1'b0 || drop_count !== '0) begin
      bad++;
      $display("FAIL reset_vals: rdy=%0b pv=%0b len=%0d rd=%02h rdv=%0b drop=%0d required 1 0 0 00 0 0",
               s_ready, pkt_valid, pkt_len, rd_data, rd_data_valid, drop_count);
    end
  endtask

  task automatic test_basic();
    logic [DW-1:0] vec [4];
    vec[0] = 8'h11; vec[1] = 8'h22; vec[2] = 8'h33; vec[3] = 8'h44;
    rd_one();
    total++;
    if (rd_data_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_in_recv: rdv=%0b required 0", rd_data_valid);
    end
    for (int i = 0; i < 4; i++) begin
      push(vec[i], i == 3);
      exp_q.push_back(vec[i]);
      if (i == 2) begin
        total++;
        if (pkt_valid !== 1'b0) begin
          bad++;
          $display("FAIL basic_early_pv: pv=%0b required 0", pkt_valid);
        end
      end
    end
    total++;
    if (pkt_valid !== 1'b1 || pkt_len !== 4'd4 || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_done: pv=%0b len=%0d rdy=%0b required 1 4 0", pkt_valid, pkt_len, s_ready);
    end
    drain_and_check("basic");
    rd_one();
    total++;
    if (rd_data_valid !== 1'b0 || rd_data !== 8'h44) begin
      bad++;
      $display("FAIL basic_overread: rdv=%0b data=%02h required 0 44", rd_data_valid, rd_data);
    end
    ack();
    total++;
    if (pkt_valid !== 1'b0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL basic_ack: pv=%0b rdy=%0b required 0 1", pkt_valid, s_ready);
    end
  endtask

  task automatic test_full_boundary();
    for (int i = 0; i < 8; i++) begin
      push(8'h80 + 8'(i), i == 7);
      exp_q.push_back(8'h80 + 8'(i));
    end
    total++;
    if (pkt_valid !== 1'b1 || pkt_len !== 4'd8) begin
      bad++;
      $display("FAIL full8: pv=%0b len=%0d required 1 8", pkt_valid, pkt_len);
    end
    drain_and_check("full8");
    ack();
    for (int i = 0; i < 9; i++) begin
      s_valid = 1'b1; s_data = 8'hD0 + 8'(i); s_last = (i == 8);
      total++;
      if (s_ready !== 1'b1) begin
        bad++;
        $display("FAIL over9_ready word %0d: rdy=%0b required 1", i, s_ready);
      end
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    total++;
    if (pkt_valid !== 1'b0 || drop_count !== 2'd1) begin
      bad++;
      $display("FAIL over9: pv=%0b drop=%0d required 0 1", pkt_valid, drop_count);
    end
    push(8'h5A, 1'b0);
    push(8'h5B, 1'b1);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h5B);
    total++;
    if (pkt_valid !== 1'b1 || pkt_len !== 4'd2) begin
      bad++;
      $display("FAIL after_drop: pv=%0b len=%0d required 1 2", pkt_valid, pkt_len);
    end
    drain_and_check("after_drop");
    ack();
  endtask

  task automatic test_backpressure();
    push(8'hC1, 1'b0);
    push(8'hC2, 1'b0);
    push(8'hC3, 1'b1);
    exp_q.push_back(8'hC1); exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
    s_valid = 1'b1; s_data = 8'hEE; s_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (s_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_ready cycle %0d: rdy=%0b required 0", i, s_ready);
      end
      tick();
    end
    drain_and_check("bp_hold");
    ack();
    total++;
    if (s_ready !== 1'b1 || pkt_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_ack: rdy=%0b pv=%0b required 1 0", s_ready, pkt_valid);
    end
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    total++;
    if (pkt_valid !== 1'b1 || pkt_len !== 4'd1) begin
      bad++;
      $display("FAIL bp_consume: pv=%0b len=%0d required 1 1", pkt_valid, pkt_len);
    end
    exp_q.push_back(8'hEE);
    drain_and_check("bp_consume");
    ack();
  endtask

  task automatic test_single();
    push(8'hA5, 1'b1);
    total++;
    if (pkt_valid !== 1'b1 || pkt_len !== 4'd1) begin
      bad++;
      $display("FAIL single_len: pv=%0b len=%0d required 1 1", pkt_valid, pkt_len);
    end
    exp_q.push_back(8'hA5);
    drain_and_check("single");
    ack();
    push(8'h3C, 1'b1);
    ack();
    total++;
    if (pkt_valid !== 1'b0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_ack_noread: pv=%0b rdy=%0b required 0 1", pkt_valid, s_ready);
    end
  endtask

  task automatic test_rd_ack_same();
    push(8'h61, 1'b0);
    push(8'h62, 1'b1);
    rd_en = 1'b1; pkt_ack = 1'b1;
    tick();
    rd_en = 1'b0; pkt_ack = 1'b0;
    total++;
    if (rd_data_valid !== 1'b1 || rd_data !== 8'h61 || pkt_valid !== 1'b0 || s_ready !== 1'b1) begin
      bad++;
      $display("FAIL rd_ack_same: rdv=%0b data=%02h pv=%0b rdy=%0b required 1 61 0 1",
               rd_data_valid, rd_data, pkt_valid, s_ready);
    end
  endtask

  task automatic test_reset_mid();
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (s_ready !== 1'b1 || pkt_valid !== 1'b0 || drop_count !== '0 || rd_data !== '0) begin
      bad++;
      $display("FAIL reset_mid: rdy=%0b pv=%0b drop=%0d rd=%02h required 1 0 0 00",
               s_ready, pkt_valid, drop_count, rd_data);
    end
    push(8'h04, 1'b0);
    push(8'h05, 1'b0);
    push(8'h06, 1'b1);
    exp_q.push_back(8'h04); exp_q.push_back(8'h05); exp_q.push_back(8'h06);
    total++;
    if (pkt_valid !== 1'b1 || pkt_len !== 4'd3) begin
      bad++;
      $display("FAIL reset_mid_pkt: pv=%0b len=%0d required 1 3", pkt_valid, pkt_len);
    end
    drain_and_check("reset_mid");
    ack();
  endtask

  task automatic test_drop_saturate();
    logic [CW-1:0] exp_drop [5];
    exp_drop[0] = 2'd1; exp_drop[1] = 2'd2; exp_drop[2] = 2'd3;
    exp_drop[3] = 2'd3; exp_drop[4] = 2'd3;
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 9 + p; i++) begin
        push(8'(p * 16 + i), i == 8 + p);
      end
      total++;
      if (drop_count !== exp_drop[p] || pkt_valid !== 1'b0) begin
        bad++;
        $display("FAIL drop_sat pkt %0d: drop=%0d pv=%0b required %0d 0",
                 p, drop_count, pkt_valid, exp_drop[p]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_boundary();
    test_backpressure();
    test_single();
    test_rd_ack_same();
    test_reset_mid();
    test_drop_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_pkt_rx.md
Name: stream_pkt_rx

Overview:
- AXI4-stream compatible packet sink. It accepts one complete packet from a stream source (for example the output of the SoC stream FIFO) into an internal buffer.
- Once the whole packet is held, it exposes the packet to the picorv32 SoC register side as a readable word sequence plus a length.
- Packets longer than the buffer are discarded whole and counted. Only one packet is held at a time; the stream is back-pressured until software releases it.

Parameters:
- AW, 8, buffer address width; capacity is 2**AW words.
- DW, 8, stream data width.
- CW, 16, width of the dropped-packet counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- s_data  input  DW  stream data.
- s_valid  input  1  stream word valid.
- s_last  input  1  final word of the packet; qualified by s_valid.
- s_ready  output  1  sink can accept a word this cycle.
- pkt_valid  output  1  a complete packet is held and readable.
- pkt_len  output  AW+1  word count of the held packet, range 1..2**AW; valid while pkt_valid.
- rd_en  input  1  pop the next packet word.
- rd_data  output  DW  popped word.
- rd_data_valid  output  1  rd_data is valid; one-cycle pulse.
- pkt_ack  input  1  software releases the held packet.
- drop_count  output  CW  number of oversize packets discarded; saturating.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: state=RECV, s_ready=1, pkt_valid=0, pkt_len=0, rd_data=0, rd_data_valid=0, drop_count=0. Write and read pointers are cleared.
- Transfer rule: a word transfers when s_valid && s_ready. A word with s_valid=0 is never written.
- RECV state: s_ready=1. Each transfer writes buffer[wcnt] and increments wcnt.
  - Transfer with s_last=1 and wcnt <= 2**AW-1 (the packet fits) -> DONE. pkt_len = wcnt+1, registered. pkt_valid=1 from the next cycle.
  - Transfer with s_last=0 when wcnt == 2**AW-1 (buffer now full, packet not ended) -> DROP.
- DROP state: s_ready=1. Words are consumed and discarded.
  - On the transfer with s_last=1 -> RECV. wcnt=0; drop_count increments, saturating at 2**CW-1.
- DONE state: s_ready=0. pkt_valid=1.
  - rd_en while rcnt < pkt_len: rd_data=buffer[rcnt] and rd_data_valid=1 on the next cycle; rcnt increments.
  - rd_en while rcnt >= pkt_len: ignored; rd_data_valid stays 0; rd_data holds its value.
  - pkt_ack -> RECV next cycle. pkt_valid=0, wcnt=0, rcnt=0. Unread words are abandoned.
- pkt_ack outside DONE: ignored.
- rd_en outside DONE: ignored.
- rd_en and pkt_ack in the same cycle in DONE: the read completes (rd_data_valid pulses next cycle) and the release takes effect.
- Full-buffer boundary:
  - A packet of exactly 2**AW words is accepted; pkt_len = 2**AW.
  - A packet of 2**AW+1 or more words is dropped.
- Single-word packet (s_last on the first word): pkt_len=1.
- Latency: last word accepted -> pkt_valid=1 one cycle later. rd_en -> rd_data_valid one cycle later.
- Back-to-back throughput: in RECV, one word per cycle. Between packets there is zero bubble in DROP and one bubble after pkt_ack.
- Reset mid-packet or mid-read: the partial packet is lost, drop_count=0, and all outputs return to their reset values the next cycle.
- Buffer: simple dual-port RAM with synchronous read. Write port is used in RECV only; read port in DONE only.

Decomposition:
- Shared package (stream_pkg): state encoding constants RECV/DROP/DONE.
- Sub-module: stream_pkt_buf, a parameterised simple dual-port RAM, 2**AW x DW, registered read.
- FSM, counters and handshake logic live in stream_pkt_rx.

Test Plan:
- Reset, then a 4-word packet 0x11,0x22,0x33,0x44 with last on 0x44 -> pkt_valid=1 the cycle after, pkt_len=4. 4x rd_en -> rd_data 0x11,0x22,0x33,0x44 with rd_data_valid each one cycle later. Fifth rd_en -> no rd_data_valid.
- AW=3: 8-word packet -> accepted, pkt_len=8. 9-word packet -> all 9 words accepted with s_ready=1, pkt_valid stays 0, drop_count=1. A following 2-word packet is received normally with pkt_len=2.
- While DONE, drive s_valid=1 for 10 cycles -> s_ready=0 throughout and the buffer is unchanged. pkt_ack -> s_ready=1 next cycle and the held words are then consumed.
- Single-word packet 0xA5 with s_last=1 -> pkt_len=1, rd_data=0xA5. pkt_ack issued before any read -> returns to RECV, pkt_valid=0.
- Assert rst after 3 words of a 6-word packet -> s_ready=1, pkt_valid=0, drop_count=0. The remaining 3 words (last on word 6) form a new 3-word packet, pkt_len=3.
- CW=2: send five oversize packets -> drop_count reads 1,2,3,3,3 (saturates).
